avmm_arb2: RTL

Two-master round-robin arbiter sharing the single Avalon-MM slave port of the system core (PIO/LED register bank) between the SPI-slave-to-Avalon bridge master (m0) and the local FX2LP command master (m1). Serialises one transfer at a time, forwards the granted master to the slave, stalls the loser with waitrequest, and aborts slave transfers that stall longer than a programmable timeout.

---
 rtl/avmm_arb2.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/avmm_arb2.sv
// ---------------------------------------------------------------------------
// avmm_arb2 : two-master Avalon-MM arbiter in front of a single slave port.
//
// m0 is the SPI-slave-to-Avalon bridge, m1 the local FX2LP command master.
// One transfer is forwarded at a time. The losing master is held off with
// waitrequest. A granted transfer that stalls TIMEOUT consecutive cycles is
// aborted: the master is released with TIMEOUT_DATA and the sticky err flag
// is raised.
//
// Parameters
//   ADDR_W        Avalon word-address width on all ports
//   TIMEOUT       stalled granted cycles tolerated before abort (0 = never)
//   TIMEOUT_DATA  readdata returned to the master on an aborted transfer
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   m0_* / m1_*                Avalon-MM slave-side ports facing each master
//   s_*                        Avalon-MM master-side port facing the slave
//   err_clr                    clears err (a same-cycle abort wins)
//   err                        sticky timeout flag
//
// Build option
//   ARB_FIXED_PRIO_EN  when defined, contention always grants m0 and the
//                      round-robin pointer is not built.
// ---------------------------------------------------------------------------
module avmm_arb2 #(
    parameter int          ADDR_W       = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic [3:0]        m0_byteenable,
    output logic [31:0]       m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic [3:0]        m1_byteenable,
    output logic [31:0]       m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    output logic [3:0]        s_byteenable,
    input  logic [31:0]       s_readdata,
    input  logic              s_waitrequest,

    input  logic              err_clr,
    output logic              err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic req0;
    logic req1;
    logic gnt_req;
    logic abort;
    logic done;
    logic pick_m1;     // contention winner while idle

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt_req = 1'b0;
        case (state)
            ST_GRANT0: gnt_req = req0;
            ST_GRANT1: gnt_req = req1;
            default:   gnt_req = 1'b0;
        endcase
    end

    // Abort only while the granted master still requests; a withdrawn
    // request is a plain return to idle with no error.
    assign abort = (TIMEOUT != 0) && gnt_req && (cnt == CNT_MAX);
    assign done  = gnt_req && !abort && !s_waitrequest;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_m1 = 1'b0;
`else
    // rr = 1 means m1 wins the next contention.
    logic rr;
    assign pick_m1 = rr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (abort || done) begin
            rr <= (state == ST_GRANT0);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            if (abort) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req0 && req1) begin
                        state <= pick_m1 ? ST_GRANT1 : ST_GRANT0;
                    end else if (req0) begin
                        state <= ST_GRANT0;
                    end else if (req1) begin
                        state <= ST_GRANT1;
                    end
                end
                default: begin
                    // Withdrawal, abort or completion all end the grant;
                    // any other granted cycle is a stall and is counted.
                    if (!gnt_req || abort || !s_waitrequest) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;

        case (state)
            ST_GRANT0: begin
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                if (abort) begin
                    m0_waitrequest = 1'b0;
                    m0_readdata    = TIMEOUT_DATA;
                end else begin
                    // Read together with write is illegal; the write wins.
                    s_read         = m0_read & ~m0_write;
                    s_write        = m0_write;
                    m0_waitrequest = s_waitrequest;
                    m0_readdata    = s_readdata;
                end
            end
            ST_GRANT1: begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                if (abort) begin
                    m1_waitrequest = 1'b0;
                    m1_readdata    = TIMEOUT_DATA;
                end else begin
                    s_read         = m1_read & ~m1_write;
                    s_write        = m1_write;
                    m1_waitrequest = s_waitrequest;
                    m1_readdata    = s_readdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
